// File: rtl/uart_mem_loader.sv
// Boot-time program loader: receives an 8N1 UART image (count byte, then little-endian
// 32-bit words) and writes each word into the instruction/data memory while holding the core.
module uart_mem_loader #(
  parameter  int MEM_DEPTH    = 8,
  parameter  int DATA_WIDTH   = 32,
  parameter  int CLKS_PER_BIT = 868,
  localparam int ADDR_WIDTH   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_rx,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_req_valid,
  output logic                  mem_we,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  frame_err
);

  localparam int CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int IDX_W    = (ADDR_WIDTH > 8) ? ADDR_WIDTH : 8;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {L_COUNT, L_DATA, L_WRITE, L_DONE} ld_state_t;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic            rx_fall;
  rx_state_t       rx_state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic [7:0]      rx_byte_q;
  logic            byte_valid_q;
  logic            frame_err_q;

  ld_state_t       ld_state_q;
  logic [7:0]      count_q;
  logic [1:0]      byte_idx_q;
  logic [IDX_W-1:0] word_idx_q;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic            mem_req_valid_q;
  logic            load_done_q;

  // The line idles high, so the synchroniser resets to 1 to avoid a false start after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (rx_fall) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) rx_state_q <= RX_STOP;
            else                   bit_idx_q  <= bit_idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt_q      <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_sync_q) begin
              byte_valid_q <= 1'b1;
              rx_byte_q    <= shift_q;
            end else begin
              frame_err_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  always_comb begin
    word_d = word_q;
    word_d[{byte_idx_q, 3'b000} +: 8] = rx_byte_q;
  end

  // Write outputs are loaded on the fourth byte so the strobe lands in the L_WRITE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_state_q      <= L_COUNT;
      count_q         <= '0;
      byte_idx_q      <= '0;
      word_idx_q      <= '0;
      word_q          <= '0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_req_valid_q <= 1'b0;
      load_done_q     <= 1'b0;
    end else begin
      mem_req_valid_q <= 1'b0;
      case (ld_state_q)
        L_COUNT: begin
          if (byte_valid_q) begin
            count_q    <= rx_byte_q;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            if (rx_byte_q == 8'd0) begin
              ld_state_q  <= L_DONE;
              load_done_q <= 1'b1;
            end else begin
              ld_state_q  <= L_DATA;
            end
          end
        end
        L_DATA: begin
          if (byte_valid_q) begin
            word_q <= word_d;
            if (byte_idx_q == 2'd3) begin
              byte_idx_q      <= '0;
              ld_state_q      <= L_WRITE;
              mem_req_valid_q <= 1'b1;
              mem_addr_q      <= ADDR_WIDTH'(word_idx_q);
              mem_wdata_q     <= word_d;
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
            end
          end
        end
        L_WRITE: begin
          word_idx_q <= word_idx_q + IDX_W'(1);
          if (word_idx_q + IDX_W'(1) == IDX_W'(count_q)) begin
            ld_state_q  <= L_DONE;
            load_done_q <= 1'b1;
          end else begin
            ld_state_q  <= L_DATA;
          end
        end
        L_DONE: ld_state_q <= L_DONE;
        default: ld_state_q <= L_COUNT;
      endcase
    end
  end

  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_we        = mem_req_valid_q;
  assign load_done     = load_done_q;
  assign cpu_hold      = ~load_done_q;
  assign frame_err     = frame_err_q;

endmodule

// File: doc/uart_mem_loader.md
# uart_mem_loader

Boot-time programmer that sits directly upstream of the 1R/1W instruction/data memory. It receives a program image over a UART serial line (8N1), assembles little-endian 32-bit words and issues one write request per word into the memory's write port. While loading, it holds the core stalled and releases it when the image is complete. It replaces hard-coded reset-time instruction initialisation in the memory.

## Interface

Parameters:
- MEM_DEPTH, 8, words in the target memory; ADDR_WIDTH = $clog2(MEM_DEPTH) (localparam)
- DATA_WIDTH, 32, memory word width; fixed at 32 (four bytes per word)
- CLKS_PER_BIT, 868, clk cycles per UART bit; must be ≥ 4

Ports:
- clk, input, 1, system clock
- reset, input, 1, asynchronous, active-high reset
- uart_rx, input, 1, serial data in; idle high; asynchronous to clk
- mem_addr, output, ADDR_WIDTH, write address to memory
- mem_wdata, output, DATA_WIDTH, write data to memory
- mem_req_valid, output, 1, one-cycle write request strobe
- mem_we, output, 1, write enable; equals mem_req_valid
- cpu_hold, output, 1, high while the image is not yet loaded; stalls the core
- load_done, output, 1, high once all announced words are written; sticky
- frame_err, output, 1, sticky flag for a bad stop bit

## Operation

- Serial frame: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1).
- uart_rx passes through a 2-flop synchroniser before any use.
- Image protocol:
  - First good byte = word count N, range 0..255.
  - Then 4·N bytes follow, little-endian per word.
  - Word k is written to address k mod MEM_DEPTH, starting at 0. Addresses wrap; there is no error on overflow.
- RX FSM:
  - RX_IDLE → RX_START on a synchronised falling edge.
  - RX_START waits CLKS_PER_BIT/2 cycles, then re-samples. If low, go to RX_DATA. If high, treat as a glitch and return to RX_IDLE.
  - RX_DATA samples 8 bits, one every CLKS_PER_BIT cycles, at mid-bit.
  - RX_STOP samples the stop bit one CLKS_PER_BIT later:
    - If 1: emit an internal byte_valid pulse for 1 cycle.
    - If 0: set frame_err, discard the byte and emit no byte_valid.
  - In both cases, return to RX_IDLE.
- Loader FSM:
  - L_COUNT: on byte_valid, latch N.
    - If N = 0, go to L_DONE.
    - Otherwise go to L_DATA, with byte_idx = 0 and word_idx = 0.
  - L_DATA: on byte_valid, shift the byte into lane byte_idx (byte 0 → bits [7:0]). When byte_idx = 3, go to L_WRITE.
  - L_WRITE lasts exactly one cycle:
    - Drive mem_req_valid = mem_we = 1, mem_addr = word_idx[ADDR_WIDTH-1:0], mem_wdata = assembled word.
    - Increment word_idx.
    - If the new word_idx = N, go to L_DONE; else go to L_DATA.
  - L_DONE is terminal until reset. Further serial bytes are received but ignored; no more writes occur.
- The loader does not wait on the memory's data_valid. The memory completes a write on the same edge on which it samples mem_req_valid.
- A discarded byte (frame error) does not advance byte_idx, so the host must resend that byte.
- Status outputs:
  - cpu_hold = !load_done.
  - load_done = 1 in L_DONE.

## Timing

- Reset values: mem_addr = 0, mem_wdata = 0, mem_req_valid = 0, mem_we = 0, cpu_hold = 1, load_done = 0, frame_err = 0. Both FSMs return to their idle states and all counters clear.
- Reset mid-load aborts the load; the next byte after reset is interpreted as a new count.
- Synchroniser latency: 2 cycles.
- byte_valid rises ~(9.5·CLKS_PER_BIT + 2) cycles after the start-bit falling edge.
- mem_req_valid is high exactly 1 cycle, in the cycle after the 4th byte_valid of a word.
- mem_addr and mem_wdata are valid in that same cycle and hold their value until the next write.
- load_done rises in the cycle after the final write (or after the count byte if N = 0).
- cpu_hold falls in that same cycle.
- Back-to-back bytes (stop bit immediately followed by a start bit) must be received without loss. Minimum byte spacing is 10·CLKS_PER_BIT, which is far more than the 1-cycle write, so no buffering is required.

## Test plan

- Loading a two-word image (CLKS_PER_BIT = 4): send 02, 13 03 a0 00, 93 03 40 01.
  - Expect exactly two mem_req_valid pulses: addr 0 ← 0x00a00313, then addr 1 ← 0x01400393.
  - Then load_done = 1, cpu_hold = 0, frame_err = 0.
- Empty image: send 00.
  - Expect no write pulses and load_done = 1 about 1 cycle after the byte.
  - Send a further byte AA: expect no write and outputs unchanged.
- Address wrap: with MEM_DEPTH = 8, send count 09 then nine words, word k = 0x1000_0000 + k.
  - Expect addresses 0..7 in order, then the 9th write at addr 0 with data 0x10000008.
- Framing error and glitch:
  - Send count 01, then one byte with stop bit = 0: expect frame_err = 1 and no byte accepted.
  - Pulse uart_rx low for 1 cycle: expect no byte.
  - Then send 4 good bytes 44 33 22 11: expect addr 0 ← 0x11223344 and load_done = 1.
- Reset mid-load: send count 02 and two data bytes, then assert reset for 3 cycles.
  - Expect all outputs back at their reset values.
  - Then send 01, 78 56 34 12: expect a single write addr 0 ← 0x12345678.
